// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and a constant-evaluable clog2.
package fifo_pkg;

    localparam int unsigned DEF_WIDTH = 64;
    localparam int unsigned DEF_DEPTH = 8;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around FIFO pointer, modulo DEPTH (DEPTH is a power of two).
// Ports:
//   i_clk   clock
//   i_rst_n asynchronous active-low reset, forces pointer to 0
//   i_en    advance pointer by one
//   i_flush synchronous clear, has priority over i_en
//   o_ptr   current pointer value
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_flush,
    output logic [clog2(DEPTH)-1:0] o_ptr
);

    localparam int unsigned PW = clog2(DEPTH);

    logic [PW-1:0] r_ptr;

    // Power-of-two depth lets the natural binary wrap implement modulo DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_flush) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= r_ptr + PW'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/param_fifo.sv
// Parametrised show-ahead synchronous FIFO with occupancy count, thresholds
// and a sticky overflow/underflow flag.
// Ports:
//   clk, rst (async active-low)
//   data_in / data_in_valid  push side
//   pop_fifo                 pop request
//   flush                    synchronous clear of pointers, count and err
//   data_out                 oldest entry, 0 when empty
//   fifo_empty, fifo_full, almost_full, almost_empty, count, err
module param_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned DEPTH         = DEF_DEPTH,
    parameter int unsigned AFULL_THRESH  = DEPTH - 1,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      data_in,
    input  logic                  data_in_valid,
    input  logic                  pop_fifo,
    input  logic                  flush,
    output logic [WIDTH-1:0]      data_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [clog2(DEPTH):0] count,
    output logic                  err
);

    localparam int unsigned PW = clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]    w_rptr;
    logic [PW-1:0]    w_wptr;
    logic [CW-1:0]    r_count;
    logic             r_err;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] w_we;
    logic             w_empty;
    logic             w_full;
    logic             w_pop_acc;
    logic             w_push_acc;
    logic             w_err_evt;

    // Status decodes from the count register only.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign w_pop_acc  = pop_fifo & ~w_empty;
    assign w_push_acc = data_in_valid & (~w_full | w_pop_acc);
    assign w_err_evt  = (data_in_valid & w_full & ~w_pop_acc) | (pop_fifo & w_empty);

    fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_en    (w_pop_acc),
        .i_flush (flush),
        .o_ptr   (w_rptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_en    (w_push_acc),
        .i_flush (flush),
        .o_ptr   (w_wptr)
    );

    // Per-entry write enable; a flush cycle writes nothing.
    always_comb begin
        w_we = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_we[i] = w_push_acc & ~flush & (w_wptr == PW'(i));
        end
    end

    // Storage array, cleared by reset only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (w_we[i]) begin
                    r_mem[i] <= data_in;
                end
            end
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (flush) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign data_out     = w_empty ? '0 : r_mem[w_rptr];
    assign fifo_empty   = w_empty;
    assign fifo_full    = w_full;
    assign almost_full  = (32'(r_count) >= AFULL_THRESH);
    assign almost_empty = (32'(r_count) <= AEMPTY_THRESH);
    assign count        = r_count;
    assign err          = r_err;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo (WIDTH=64, DEPTH=4, AFULL=3, AEMPTY=1): directed
// corner cases plus randomized traffic against a queue reference model.
module tb_param_fifo;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] data_in;
    logic        data_in_valid;
    logic        pop_fifo;
    logic        flush;
    logic [63:0] data_out;
    logic        fifo_empty;
    logic        fifo_full;
    logic        almost_full;
    logic        almost_empty;
    logic [2:0]  count;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;

    logic [63:0] q[$];
    logic        m_err;

    param_fifo #(
        .WIDTH(64), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .pop_fifo      (pop_fifo),
        .flush         (flush),
        .data_out      (data_out),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .count         (count),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the reference queue.
    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"},  64'(count),        64'(n));
        chk({tag, ".empty"},  64'(fifo_empty),   64'(n == 0));
        chk({tag, ".full"},   64'(fifo_full),    64'(n == D));
        chk({tag, ".afull"},  64'(almost_full),  64'(n >= 3));
        chk({tag, ".aempty"}, 64'(almost_empty), 64'(n <= 1));
        chk({tag, ".dout"},   data_out,          (n > 0) ? q[0] : 64'h0);
        chk({tag, ".err"},    64'(err),          64'(m_err));
    endtask

    // One clock: drive request, apply model rules at the edge, then check.
    task automatic step(input string tag, input logic psh, input logic pp,
                        input logic fl, input logic [63:0] din);
        int n;
        bit pa;
        bit sa;
        data_in       = din;
        data_in_valid = psh;
        pop_fifo      = pp;
        flush         = fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            n  = q.size();
            pa = pp && (n > 0);
            sa = psh && ((n < D) || pa);
            if ((psh && (n == D) && !pa) || (pp && (n == 0))) m_err = 1'b1;
            if (pa) void'(q.pop_front());
            if (sa) q.push_back(din);
        end
        #1;
        data_in_valid = 1'b0;
        pop_fifo      = 1'b0;
        flush         = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [63:0] v;
        bit          psh;
        bit          pp;
        bit          fl;
        int          bias;
        rst           = 1'b0;
        data_in       = '0;
        data_in_valid = 1'b0;
        pop_fifo      = 1'b0;
        flush         = 1'b0;
        m_err         = 1'b0;
        #1;
        check_all("reset");
        #12 rst = 1'b1;

        // Fill to full.
        for (int i = 0; i < 4; i++) step("fill", 1'b1, 1'b0, 1'b0, 64'hA + 64'(i));
        chk("r36_count", 64'(count), 64'd4);
        chk("r36_full",  64'(fifo_full), 64'd1);
        chk("r36_afull", 64'(almost_full), 64'd1);
        chk("r36_dout",  data_out, 64'hA);
        chk("r36_err",   64'(err), 64'd0);

        // Overflow, then drain in order.
        step("ovf", 1'b1, 1'b0, 1'b0, 64'hE);
        chk("r37_err",   64'(err), 64'd1);
        chk("r37_count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("r37_dout", data_out, 64'hA + 64'(i));
            step("drain", 1'b0, 1'b1, 1'b0, 64'h0);
        end
        chk("r37_empty", 64'(fifo_empty), 64'd1);
        step("flush1", 1'b0, 1'b0, 1'b1, 64'h0);
        chk("flush_err", 64'(err), 64'd0);

        // Simultaneous push/pop while full, wrap-around.
        for (int i = 0; i < 4; i++) step("fill2", 1'b1, 1'b0, 1'b0, 64'hA + 64'(i));
        step("pp_full", 1'b1, 1'b1, 1'b0, 64'hE);
        chk("r38_count", 64'(count), 64'd4);
        chk("r38_dout",  data_out, 64'hB);
        chk("r38_err",   64'(err), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("r38_dout_seq", data_out, 64'hB + 64'(i));
            step("drain2", 1'b0, 1'b1, 1'b0, 64'h0);
        end

        // Push and pop on empty.
        step("pp_empty", 1'b1, 1'b1, 1'b0, 64'h5);
        chk("r39_count", 64'(count), 64'd1);
        chk("r39_dout",  data_out, 64'h5);
        chk("r39_err",   64'(err), 64'd1);

        // Asynchronous reset between edges with two entries held.
        step("second", 1'b1, 1'b0, 1'b0, 64'h6);
        #2 rst = 1'b0;
        #1;
        q.delete();
        m_err = 1'b0;
        check_all("async_rst");
        chk("r40_count", 64'(count), 64'd0);
        chk("r40_dout",  data_out, 64'h0);
        #3 rst = 1'b1;
        step("post_rst", 1'b1, 1'b0, 1'b0, 64'h77);
        chk("r32_dout", data_out, 64'h77);

        // Flush a 3-entry FIFO with err set.
        step("flush2", 1'b0, 1'b0, 1'b1, 64'h0);
        step("udf", 1'b0, 1'b1, 1'b0, 64'h0);
        chk("udf_err", 64'(err), 64'd1);
        for (int i = 0; i < 3; i++) step("fill3", 1'b1, 1'b0, 1'b0, 64'h100 + 64'(i));
        step("flush3", 1'b1, 1'b1, 1'b1, 64'hDEAD);
        chk("r40_fl_count", 64'(count), 64'd0);
        chk("r40_fl_err",   64'(err), 64'd0);

        // Randomized traffic with phases biased towards filling or draining.
        for (int i = 0; i < 10000; i++) begin
            bias = ((i / 500) % 2 == 0) ? 70 : 30;
            psh  = ($urandom_range(0, 99) < bias);
            pp   = ($urandom_range(0, 99) < (100 - bias));
            fl   = ($urandom_range(0, 199) == 0);
            v    = {$urandom, $urandom};
            step("rnd", psh, pp, fl, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
